data_sampling_cfg: RTL and testbench
====================================

Name: data_sampling_cfg

Overview:
- Parametrised successor to the UART RX data-sampling stage.
- Samples rx_in at runtime-selectable oversampling ratios of 8, 16 or 32 clocks per bit, using an edge counter supplied by the RX edge/bit counter.
- Resolves each bit by 3-sample majority vote or by single centre sample, and emits a one-cycle sample_valid strobe with the resolved bit.
- Sits between the edge/bit counter and the RX FSM, parity checker and deserializer.

Parameters:
- PRESCALE_W, 6, width of prescale and edge_cnt; the largest legal prescale is 2^(PRESCALE_W-1).
- RST_BIT, 1'b1, reset and idle value of sampled_bit (line idle level).

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- rst  in  1  asynchronous active-low reset.
- rx_in  in  1  serial line, already synchronised upstream.
- data_samp_en  in  1  sampling enable from the RX FSM.
- prescale  in  PRESCALE_W  clocks per bit; legal values are 8, 16 and 32.
- edge_cnt  in  PRESCALE_W  position within the bit, counting 0..prescale-1.
- maj_mode  in  1  1 selects 3-sample majority; 0 selects single centre sample.
- sampled_bit  out  1  resolved bit value.
- sample_valid  out  1  one-cycle pulse marking a new sampled_bit.
- cfg_err  out  1  level output; high while prescale is illegal.

Behaviour:
- Reset (rst=0, asynchronous):
  - sampled_bit=RST_BIT, sample_valid=0, cfg_err=0.
  - Sample registers s[2:0]=0 and capture flags f[2:0]=0.
- Centre position: c = prescale>>1. Sample points are P0=c-1, P1=c, P2=c+1.
- Legal prescale: a power of two in the range 8..2^(PRESCALE_W-1).
  - Any other prescale value holds f=0, never pulses sample_valid, and drives cfg_err=1 from the next cycle.
  - sampled_bit holds its last value while prescale is illegal.
- Capture, when data_samp_en=1 and edge_cnt==Pk: s[k]<=rx_in and f[k]<=1.
- Flag clearing:
  - f clears on any cycle with edge_cnt==0 or data_samp_en=0.
  - A bit interrupted by an enable drop therefore never produces a valid strobe.
- Resolve, on the cycle when edge_cnt==P2 and data_samp_en=1:
  - In majority mode, if f[0]&f[1] are set, the next edge updates sampled_bit to maj(s0,s1,rx_in) and asserts sample_valid=1 for exactly one cycle.
  - rx_in is used directly for the third sample, so latency is 1 clock after P2.
  - In single mode (maj_mode=0), if f[1] is set, sampled_bit<=s[1] with the same strobe timing at P2+1. Latency is identical in both modes.
- Simultaneous events:
  - edge_cnt==P2 together with data_samp_en falling (data_samp_en=0 on that cycle): no strobe.
  - A prescale change takes effect immediately. Flags captured under the old ratio remain, but the capture points move to the new ratio's P0..P2. Software changes prescale only while RX is idle.
- maj_mode is sampled at the resolve cycle only.
- edge_cnt values at or above prescale are ignored; no capture occurs.
- sample_valid is never high on two consecutive cycles.

Optional Feature:
- Macro: DATA_SAMPLING_NOISE_EN.
- When defined, output noise_err (1 bit, reset 0) is added.
  - It pulses together with sample_valid when the three majority samples disagree (s0, s1 and the P2 sample not all equal). It is gated to 0 in single mode.
- When undefined, the port and its logic are absent. Resolve behaviour is unchanged either way.

Decomposition:
- Package uart_rx_pkg holds:
  - Legal prescale constants PRESCALE_8, PRESCALE_16 and PRESCALE_32.
  - Sample-index localparams IDX_PRE, IDX_MID and IDX_POST.
  - A maj3 function shared with the start-bit and stop-bit checks.
- Sub-module sample_point_decode: combinational. It takes prescale and edge_cnt and produces the hit_p0, hit_p1 and hit_p2 decodes and prescale_legal. It is reused by the start-bit glitch filter.

Test Plan:
- Majority at prescale=8: rx_in=1,0,1 at edge_cnt 3,4,5 with maj_mode=1 → sampled_bit=1 and sample_valid pulse on the cycle after edge_cnt=5. With NOISE_EN, noise_err=1.
- Majority at prescale=16: rx_in=0,0,1 at edge_cnt 7,8,9 → sampled_bit=0 and one strobe at edge_cnt=10; noise_err=1.
- Majority at prescale=32: rx_in=1 at 15,16,17 → sampled_bit=1, noise_err=0. Repeat over 10 back-to-back bits → exactly 10 strobes, each 32 clocks apart.
- Single mode, prescale=16: maj_mode=0, rx_in=1,0,1 at 7,8,9 → sampled_bit=0 and strobe at edge_cnt=10.
- Interrupted bit: data_samp_en drops at edge_cnt=8 with prescale=16 → no strobe and sampled_bit unchanged. The next full bit resolves normally.
- Illegal config and reset: prescale=12 → cfg_err=1 and no strobes for 3 bit periods. Asserting rst=0 at edge_cnt=4 with prescale=8 → outputs go immediately to sampled_bit=1, sample_valid=0, cfg_err=0; no strobe for that bit.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared constants and helpers for the UART receive path: the legal
//   oversampling ratios, the indices of the three samples taken around the
//   bit centre, and the 3-input majority function used by the data-sampling
//   stage and by the start-bit / stop-bit checks.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  // Legal clocks-per-bit ratios.
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Sample positions around the bit centre: centre-1, centre, centre+1.
  localparam int IDX_PRE  = 0;
  localparam int IDX_MID  = 1;
  localparam int IDX_POST = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sample_point_decode.sv
// -----------------------------------------------------------------------------
// sample_point_decode
//   Purely combinational decode of the three sample points of a bit and of
//   the legality of the oversampling ratio. Also used by the start-bit
//   glitch filter.
//
//   Ports
//     prescale_i        clocks per bit
//     edge_cnt_i        position within the bit, 0..prescale-1
//     hit_p0_o          edge_cnt == centre-1
//     hit_p1_o          edge_cnt == centre
//     hit_p2_o          edge_cnt == centre+1
//     prescale_legal_o  prescale is a power of two in 8..2^(PRESCALE_W-1)
//
//   Hits are suppressed while prescale is illegal and for edge_cnt values at
//   or beyond prescale. PRESCALE_W must be at least 4.
// -----------------------------------------------------------------------------
module sample_point_decode
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [PRESCALE_W-1:0] edge_cnt_i,
  output logic                  hit_p0_o,
  output logic                  hit_p1_o,
  output logic                  hit_p2_o,
  output logic                  prescale_legal_o
);

  typedef logic [PRESCALE_W-1:0] cnt_t;

  localparam cnt_t PS_MIN = cnt_t'(PRESCALE_8);
  localparam cnt_t PS_MAX = cnt_t'(1) << (PRESCALE_W - 1);

  cnt_t centre;
  logic pow2;
  logic pos_ok;

  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    centre           = prescale_i >> 1;
    pow2             = (prescale_i != '0) &&
                       ((prescale_i & (prescale_i - cnt_t'(1))) == '0);
    prescale_legal_o = pow2 && (prescale_i >= PS_MIN) && (prescale_i <= PS_MAX);
    pos_ok           = prescale_legal_o && (edge_cnt_i < prescale_i);
    hit_p0_o         = pos_ok && (edge_cnt_i == centre - cnt_t'(1));
    hit_p1_o         = pos_ok && (edge_cnt_i == centre);
    hit_p2_o         = pos_ok && (edge_cnt_i == centre + cnt_t'(1));
  end

endmodule

// File: rtl/data_sampling_cfg.sv
// -----------------------------------------------------------------------------
// data_sampling_cfg
//   UART RX data-sampling stage with runtime-selectable oversampling
//   (8/16/32 clocks per bit). Each bit is resolved either by a 3-sample
//   majority vote around the bit centre or by the single centre sample, and
//   announced with a one-cycle sample_valid strobe one clock after the last
//   sample point.
//
//   Ports
//     clk           system clock, rising edge
//     rst           asynchronous reset, active low
//     rx_in         synchronised serial line
//     data_samp_en  sampling enable from the RX FSM
//     prescale      clocks per bit (8, 16 or 32 legal)
//     edge_cnt      position within the bit, 0..prescale-1
//     maj_mode      1: 3-sample majority, 0: single centre sample
//     sampled_bit   resolved bit value (RST_BIT after reset)
//     sample_valid  one-cycle strobe marking a new sampled_bit
//     cfg_err       high (registered) while prescale is illegal
//     noise_err     only with DATA_SAMPLING_NOISE_EN: pulses with
//                   sample_valid when the three majority samples disagree
//
//   Build option: define DATA_SAMPLING_NOISE_EN to add noise_err.
// -----------------------------------------------------------------------------
module data_sampling_cfg
  import uart_rx_pkg::*;
#(
  parameter int   PRESCALE_W = 6,
  parameter logic RST_BIT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  data_samp_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_cnt,
  input  logic                  maj_mode,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic                  cfg_err
`ifdef DATA_SAMPLING_NOISE_EN
  ,
  output logic                  noise_err
`endif
);

  logic hit_p0, hit_p1, hit_p2, prescale_legal;

  sample_point_decode #(
    .PRESCALE_W(PRESCALE_W)
  ) u_decode (
    .prescale_i      (prescale),
    .edge_cnt_i      (edge_cnt),
    .hit_p0_o        (hit_p0),
    .hit_p1_o        (hit_p1),
    .hit_p2_o        (hit_p2),
    .prescale_legal_o(prescale_legal)
  );

  // Only the first two samples are stored; the post-centre sample is taken
  // straight from rx_in on the resolve cycle. All three capture flags are
  // kept: f[IDX_POST] marks that this bit has already reached its resolve
  // point, so a stalled edge_cnt can never produce a second strobe.
  logic [IDX_MID:IDX_PRE]  s_q, s_d;
  logic [IDX_POST:IDX_PRE] f_q, f_d;
  logic sampled_bit_q, sampled_bit_d;
  logic sample_valid_q, sample_valid_d;
  logic cfg_err_q, cfg_err_d;
  logic noise_q, noise_d;
  logic flag_clr, resolve;

  always_comb begin
    s_d            = s_q;
    f_d            = f_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    noise_d        = 1'b0;
    cfg_err_d      = ~prescale_legal;

    // A new bit (edge_cnt==0), a dropped enable or an illegal ratio discards
    // any partially captured bit.
    flag_clr = ~prescale_legal || ~data_samp_en || (edge_cnt == '0);
    resolve  = data_samp_en && hit_p2 && ~f_q[IDX_POST];

    if (flag_clr) begin
      f_d = '0;
    end else begin
      if (hit_p0) begin
        s_d[IDX_PRE] = rx_in;
        f_d[IDX_PRE] = 1'b1;
      end
      if (hit_p1) begin
        s_d[IDX_MID] = rx_in;
        f_d[IDX_MID] = 1'b1;
      end
      if (hit_p2) begin
        f_d[IDX_POST] = 1'b1;
      end
    end

    if (resolve) begin
      if (maj_mode) begin
        if (f_q[IDX_PRE] && f_q[IDX_MID]) begin
          sample_valid_d = 1'b1;
          sampled_bit_d  = maj3(s_q[IDX_PRE], s_q[IDX_MID], rx_in);
          noise_d        = ~((s_q[IDX_PRE] == s_q[IDX_MID]) &&
                             (s_q[IDX_MID] == rx_in));
        end
      end else if (f_q[IDX_MID]) begin
        sample_valid_d = 1'b1;
        sampled_bit_d  = s_q[IDX_MID];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  // NOTE: every register, sample storage included, has a defined reset value
  // so the stage never strobes out a bit assembled before reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q            <= '0;
      f_q            <= '0;
      sampled_bit_q  <= RST_BIT;
      sample_valid_q <= 1'b0;
      cfg_err_q      <= 1'b0;
      noise_q        <= 1'b0;
    end else begin
      s_q            <= s_d;
      f_q            <= f_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      cfg_err_q      <= cfg_err_d;
      noise_q        <= noise_d;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;
  assign cfg_err      = cfg_err_q;

`ifdef DATA_SAMPLING_NOISE_EN
  assign noise_err = noise_q;
`else
  // Without the noise output the disagreement flag has no consumer.
  logic noise_unused;
  assign noise_unused = noise_q;
`endif

endmodule

// File: tb/tb_data_sampling_cfg.sv
// -----------------------------------------------------------------------------
// tb_data_sampling_cfg
//   Self-checking bench for data_sampling_cfg. Stimulus tasks drive one bit
//   period at a time and push the expected resolved bit (and its strobe
//   cycle) into a scoreboard; a monitor pops and compares on every strobe.
// -----------------------------------------------------------------------------
module tb_data_sampling_cfg;
  import uart_rx_pkg::*;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_in = 1'b1;
  logic         data_samp_en = 1'b0;
  logic         maj_mode = 1'b1;
  logic [W-1:0] prescale = W'(8);
  logic [W-1:0] edge_cnt = '0;
  logic         sampled_bit;
  logic         sample_valid;
  logic         cfg_err;
`ifdef DATA_SAMPLING_NOISE_EN
  logic         noise_err;
`endif

  data_sampling_cfg #(
    .PRESCALE_W(W),
    .RST_BIT   (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .data_samp_en(data_samp_en),
    .prescale    (prescale),
    .edge_cnt    (edge_cnt),
    .maj_mode    (maj_mode),
    .sampled_bit (sampled_bit),
    .sample_valid(sample_valid),
    .cfg_err     (cfg_err)
`ifdef DATA_SAMPLING_NOISE_EN
    ,
    .noise_err   (noise_err)
`endif
  );

  typedef struct {
    logic val;
    logic noise;
    int   cyc;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   strobes    = 0;
  logic exp_last   = 1'b1;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor: every strobe must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sample_valid) begin
      strobes++;
      compared++;
      if (prev_valid) begin
        mismatched++;
        $display("FAIL consecutive_valid: sample_valid high two cycles in a row at cycle %0d", cyc);
      end
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_strobe: strobe at cycle %0d bit=%b, none expected", cyc, sampled_bit);
      end else begin
        e = sb.pop_front();
        compared++;
        if (sampled_bit !== e.val) begin
          mismatched++;
          $display("FAIL strobe_bit: got %b expected %b (cycle %0d)", sampled_bit, e.val, cyc);
        end
        compared++;
        if (cyc !== e.cyc) begin
          mismatched++;
          $display("FAIL strobe_cycle: got %0d expected %0d", cyc, e.cyc);
        end
`ifdef DATA_SAMPLING_NOISE_EN
        compared++;
        if (noise_err !== e.noise) begin
          mismatched++;
          $display("FAIL noise_err: got %b expected %b (cycle %0d)", noise_err, e.noise, cyc);
        end
`endif
      end
    end
    prev_valid = sample_valid;
  end

  // Drive one full bit period. r0/r1/r2 land on centre-1/centre/centre+1;
  // every other position carries random line data. maj_mode is random except
  // on the resolve cycle. data_samp_en drops from edge drop_at (<0: never).
  task automatic drive_bit(input int p, input logic r0, input logic r1,
                           input logic r2, input logic maj, input int drop_at,
                           input logic expect_strobe);
    int c = p / 2;
    for (int e = 0; e < p; e++) begin
      prescale     = W'(p);
      edge_cnt     = W'(e);
      data_samp_en = (drop_at < 0) || (e < drop_at);
      maj_mode     = (e == c + 1) ? maj : 1'($urandom_range(0, 1));
      if (e == c - 1)      rx_in = r0;
      else if (e == c)     rx_in = r1;
      else if (e == c + 1) rx_in = r2;
      else                 rx_in = 1'($urandom_range(0, 1));
      if (e == c + 1 && expect_strobe) begin
        exp_t x;
        x.val   = maj ? ((r0 & r1) | (r0 & r2) | (r1 & r2)) : r1;
        x.noise = maj && !((r0 == r1) && (r1 == r2));
        x.cyc   = cyc + 1;
        sb.push_back(x);
        exp_last = x.val;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++;
    if (sampled_bit !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_sampled_bit: got %b expected 1", sampled_bit);
    end
    compared++;
    if (sample_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_sample_valid: got %b expected 0", sample_valid);
    end
    compared++;
    if (cfg_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_cfg_err: got %b expected 0", cfg_err);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_majority();
    drive_bit(PRESCALE_8,  1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    drive_bit(PRESCALE_16, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    drive_bit(PRESCALE_32, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1);
  endtask

  task automatic test_back_to_back();
    int s0 = strobes;
    for (int i = 0; i < 10; i++)
      drive_bit(PRESCALE_32, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1, -1, 1'b1);
    compared++;
    if (strobes - s0 !== 10) begin
      mismatched++;
      $display("FAIL back_to_back_count: got %0d strobes expected 10", strobes - s0);
    end
  endtask

  task automatic test_single();
    drive_bit(PRESCALE_16, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b1);
    drive_bit(PRESCALE_8,  1'b0, 1'b1, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_interrupted();
    int s0;
    drive_bit(PRESCALE_16, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    s0 = strobes;
    drive_bit(PRESCALE_16, 1'b1, 1'b1, 1'b1, 1'b1, 8, 1'b0);
    compared++;
    if (sampled_bit !== exp_last) begin
      mismatched++;
      $display("FAIL interrupted_hold: got %b expected %b", sampled_bit, exp_last);
    end
    compared++;
    if (strobes !== s0) begin
      mismatched++;
      $display("FAIL interrupted_strobe: got %0d strobes expected 0", strobes - s0);
    end
    drive_bit(PRESCALE_16, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b1);
  endtask

  task automatic test_illegal();
    int s0 = strobes;
    logic hold = exp_last;
    for (int i = 0; i < 36; i++) begin
      prescale     = W'(12);
      edge_cnt     = W'(i % 12);
      data_samp_en = 1'b1;
      maj_mode     = 1'($urandom_range(0, 1));
      rx_in        = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      if (i == 0) begin
        compared++;
        if (cfg_err !== 1'b1) begin
          mismatched++;
          $display("FAIL cfg_err_rise: got %b expected 1", cfg_err);
        end
      end
    end
    compared++;
    if (cfg_err !== 1'b1) begin
      mismatched++;
      $display("FAIL cfg_err_level: got %b expected 1", cfg_err);
    end
    compared++;
    if (sampled_bit !== hold) begin
      mismatched++;
      $display("FAIL illegal_hold: got %b expected %b", sampled_bit, hold);
    end
    compared++;
    if (strobes !== s0) begin
      mismatched++;
      $display("FAIL illegal_strobe: got %0d strobes expected 0", strobes - s0);
    end
    // Asynchronous reset clears cfg_err without waiting for a clock edge.
    rst = 1'b0;
    #1;
    compared++;
    if (cfg_err !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_clears_cfg_err: got %b expected 0", cfg_err);
    end
    exp_last = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset_mid_bit();
    int s0;
    drive_bit(PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    compared++;
    if (cfg_err !== 1'b0) begin
      mismatched++;
      $display("FAIL cfg_err_legal: got %b expected 0", cfg_err);
    end
    s0 = strobes;
    for (int e = 0; e < 8; e++) begin
      prescale     = W'(PRESCALE_8);
      edge_cnt     = W'(e);
      data_samp_en = 1'b1;
      maj_mode     = 1'b1;
      rx_in        = 1'b0;
      if (e == 4) begin
        #1 rst = 1'b0;
        #1;
        compared++;
        if (sampled_bit !== 1'b1) begin
          mismatched++;
          $display("FAIL midbit_reset_bit: got %b expected 1", sampled_bit);
        end
        compared++;
        if (sample_valid !== 1'b0) begin
          mismatched++;
          $display("FAIL midbit_reset_valid: got %b expected 0", sample_valid);
        end
        compared++;
        if (cfg_err !== 1'b0) begin
          mismatched++;
          $display("FAIL midbit_reset_cfg_err: got %b expected 0", cfg_err);
        end
      end
      @(posedge clk);
      #1;
      if (e == 4) rst = 1'b1;
    end
    exp_last = 1'b1;
    compared++;
    if (strobes !== s0) begin
      mismatched++;
      $display("FAIL midbit_reset_strobe: got %0d strobes expected 0", strobes - s0);
    end
    drive_bit(PRESCALE_8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1);
  endtask

  task automatic test_drain();
    data_samp_en = 1'b0;
    edge_cnt     = '0;
    repeat (4) @(posedge clk);
    #1;
    compared++;
    if (sb.size() !== 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d expected strobes never seen", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_back_to_back();
    test_single();
    test_interrupted();
    test_illegal();
    test_reset_mid_bit();
    test_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
